// File: rtl/jtframe_obj_pkg.sv
// Shared types and constants for the object row drawer.
package jtframe_obj_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAW} obj_st_e;
  localparam int unsigned OBJ_WORDS        = 4;
  localparam int unsigned OBJ_PXL_PER_WORD = 4;
endpackage

// File: rtl/jtframe_obj_pxlsel.sv
// Picks one 4bpp nibble out of a 16-bit ROM word, honouring horizontal flip.
module jtframe_obj_pxlsel (
  input  logic [15:0] data,
  input  logic [1:0]  p,
  input  logic        hflip,
  output logic [3:0]  nibble
);
  logic [1:0] idx;

  always_comb begin
    // Unflipped rows start at the top nibble, flipped rows at the bottom one
    idx = hflip ? p : ~p;
    unique case (idx)
      2'd0: nibble = data[3:0];
      2'd1: nibble = data[7:4];
      2'd2: nibble = data[11:8];
      2'd3: nibble = data[15:12];
    endcase
  end
endmodule

// File: rtl/jtframe_obj_draw.sv
// Sprite row drawer: fetches four 16-bit ROM words of one sprite row and
// writes the 16 resulting pixels, palette-tagged, into a line buffer.
module jtframe_obj_draw import jtframe_obj_pkg::*; #(
  parameter int CW = 7,
  parameter int PW = 4,
  parameter int XW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          draw,
  input  logic [CW-1:0] code,
  input  logic [3:0]    vrow,
  input  logic          hflip,
  input  logic [PW-1:0] pal,
  input  logic [XW-1:0] xpos,
  output logic          busy,
  output logic          obj_cs,
  output logic [CW+5:0] obj_addr,
  input  logic [15:0]   obj_data,
  input  logic          obj_ok,
  output logic [XW-1:0] buf_addr,
  output logic [PW+3:0] buf_data,
  output logic          buf_we
);
  obj_st_e       st, st_nx;
  logic [CW-1:0] code_l;
  logic [3:0]    vrow_l;
  logic          hflip_l;
  logic [PW-1:0] pal_l;
  logic [XW-1:0] x;
  logic [1:0]    w, p;
  logic          armed;
  logic [15:0]   data_l;
  logic          last_pxl, last_word, take, emit;
  logic [15:0]   sel_data;
  logic [1:0]    sel_p;
  logic [3:0]    nib;

  always_comb begin
    last_pxl  = p == 2'(OBJ_PXL_PER_WORD - 1);
    last_word = w == 2'(OBJ_WORDS - 1);
    take      = (st == FETCH) && armed && obj_ok;
    emit      = take || ((st == DRAW) && !last_pxl);
    // buf_* are registered, so the pixel is chosen one cycle ahead: the
    // incoming ROM word for pixel 0, the latched word for the rest
    sel_data  = (st == FETCH) ? obj_data : data_l;
    sel_p     = (st == FETCH) ? 2'd0 : p + 2'd1;
  end

  jtframe_obj_pxlsel u_pxlsel (
    .data   (sel_data),
    .p      (sel_p),
    .hflip  (hflip_l),
    .nibble (nib)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:  if (draw) st_nx = FETCH;
      FETCH: if (take) st_nx = DRAW;
      DRAW:  if (last_pxl) st_nx = last_word ? IDLE : FETCH;
      default: st_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = st != IDLE;
    obj_cs   = st == FETCH;
    obj_addr = {code_l, vrow_l, hflip_l ? ~w : w};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_l   <= '0;
      vrow_l   <= '0;
      hflip_l  <= 1'b0;
      pal_l    <= '0;
      x        <= '0;
      w        <= '0;
      p        <= '0;
      armed    <= 1'b0;
      data_l   <= '0;
      buf_addr <= '0;
      buf_data <= '0;
      buf_we   <= 1'b0;
    end else begin
      buf_we <= 1'b0;
      unique case (st)
        IDLE: if (draw) begin
          code_l  <= code;
          vrow_l  <= vrow;
          hflip_l <= hflip;
          pal_l   <= pal;
          x       <= xpos;
          w       <= '0;
          armed   <= 1'b0;
        end
        FETCH: begin
          // ok on the first FETCH cycle may belong to the previous word
          armed <= 1'b1;
          if (take) begin
            data_l <= obj_data;
            p      <= '0;
          end
        end
        DRAW: begin
          if (!last_pxl) p <= p + 2'd1;
          else begin
            armed <= 1'b0;
            if (!last_word) w <= w + 2'd1;
          end
        end
        default: ;
      endcase
      if (emit) begin
        buf_addr <= x;
        x        <= x + 1'b1;
        buf_data <= {pal_l, nib};
        buf_we   <= nib != '0;
      end
    end
  end
endmodule

// File: tb/tb_jtframe_obj_draw.sv
// Directed self-checking bench for the object row drawer.
module tb_jtframe_obj_draw;
  logic        clk, rst, draw, hflip, busy, obj_cs, obj_ok, buf_we;
  logic [6:0]  code;
  logic [3:0]  vrow, pal;
  logic [8:0]  xpos, buf_addr;
  logic [12:0] obj_addr;
  logic [15:0] obj_data;
  logic [7:0]  buf_data;
  logic [15:0] rom [4];

  int checks = 0;
  int failures = 0;

  logic [12:0] cap_addr[$];
  logic [8:0]  cap_x[$];
  logic [7:0]  cap_d[$];
  int          cap_busy;
  bit          cap_to;

  jtframe_obj_draw #(.CW(7), .PW(4), .XW(9)) dut (
    .clk(clk), .rst(rst), .draw(draw), .code(code), .vrow(vrow),
    .hflip(hflip), .pal(pal), .xpos(xpos), .busy(busy), .obj_cs(obj_cs),
    .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
    .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb obj_data = rom[obj_addr[1:0]];

  task automatic start_draw(input logic [6:0] c, input logic [3:0] v,
                            input logic h, input logic [3:0] pl,
                            input logic [8:0] xp);
    code = c; vrow = v; hflip = h; pal = pl; xpos = xp; draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
  endtask

  // Records fetch addresses, writes and busy cycles until busy drops
  task automatic capture(input int max_cyc);
    bit prev_cs;
    cap_addr.delete(); cap_x.delete(); cap_d.delete();
    cap_busy = 0; cap_to = 1'b0; prev_cs = 1'b0;
    while (busy === 1'b1) begin
      if (cap_busy >= max_cyc) begin cap_to = 1'b1; break; end
      cap_busy++;
      if (obj_cs && !prev_cs) cap_addr.push_back(obj_addr);
      if (buf_we) begin cap_x.push_back(buf_addr); cap_d.push_back(buf_data); end
      prev_cs = obj_cs;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, obj_cs, obj_addr, buf_addr, buf_data, buf_we} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%0h exp=0",
               {busy, obj_cs, obj_addr, buf_addr, buf_data, buf_we});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_normal();
    rom = '{default: 16'h1234};
    obj_ok = 1'b1;
    start_draw(7'h05, 4'd3, 1'b0, 4'hA, 9'd100);
    capture(100);
    checks++; if (cap_to) begin failures++; $display("FAIL norm_timeout got=1 exp=0"); end
    checks++; if (cap_busy != 24) begin failures++; $display("FAIL norm_busy got=%0d exp=24", cap_busy); end
    checks++;
    if (cap_addr.size() != 4) begin failures++; $display("FAIL norm_naddr got=%0d exp=4", cap_addr.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_addr[i] !== 13'h14C + 13'(i)) begin failures++; $display("FAIL norm_addr%0d got=%0h exp=%0h", i, cap_addr[i], 13'h14C + 13'(i)); end
    end
    checks++;
    if (cap_x.size() != 16) begin failures++; $display("FAIL norm_nwr got=%0d exp=16", cap_x.size()); end
    else for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap_x[i] !== 9'(100 + i) || cap_d[i] !== {4'hA, 4'(i % 4 + 1)}) begin
        failures++;
        $display("FAIL norm_wr%0d got=%0d/%0h exp=%0d/%0h", i, cap_x[i], cap_d[i], 100 + i, {4'hA, 4'(i % 4 + 1)});
      end
    end
  endtask

  task automatic test_hflip();
    rom = '{default: 16'h1234};
    start_draw(7'h05, 4'd3, 1'b1, 4'h6, 9'd100);
    capture(100);
    checks++; if (cap_busy != 24 || cap_to) begin failures++; $display("FAIL flip_busy got=%0d exp=24", cap_busy); end
    checks++;
    if (cap_addr.size() != 4) begin failures++; $display("FAIL flip_naddr got=%0d exp=4", cap_addr.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_addr[i] !== 13'h14F - 13'(i)) begin failures++; $display("FAIL flip_addr%0d got=%0h exp=%0h", i, cap_addr[i], 13'h14F - 13'(i)); end
    end
    checks++;
    if (cap_x.size() != 16) begin failures++; $display("FAIL flip_nwr got=%0d exp=16", cap_x.size()); end
    else for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap_x[i] !== 9'(100 + i) || cap_d[i] !== {4'h6, 4'(4 - i % 4)}) begin
        failures++;
        $display("FAIL flip_wr%0d got=%0d/%0h exp=%0d/%0h", i, cap_x[i], cap_d[i], 100 + i, {4'h6, 4'(4 - i % 4)});
      end
    end
  endtask

  task automatic test_wrap();
    // x runs 510,511,0..13: opaque pixels only at 511 (word 0) and 13 (word 3)
    rom = '{16'h0A00, 16'h0000, 16'h0000, 16'h000F};
    start_draw(7'h11, 4'd0, 1'b0, 4'h3, 9'd510);
    capture(100);
    checks++; if (cap_busy != 24 || cap_to) begin failures++; $display("FAIL wrap_busy got=%0d exp=24", cap_busy); end
    checks++;
    if (cap_x.size() != 2) begin failures++; $display("FAIL wrap_nwr got=%0d exp=2", cap_x.size()); end
    else begin
      checks++;
      if (cap_x[0] !== 9'd511 || cap_d[0] !== 8'h3A) begin failures++; $display("FAIL wrap_wr0 got=%0d/%0h exp=511/3a", cap_x[0], cap_d[0]); end
      checks++;
      if (cap_x[1] !== 9'd13 || cap_d[1] !== 8'h3F) begin failures++; $display("FAIL wrap_wr1 got=%0d/%0h exp=13/3f", cap_x[1], cap_d[1]); end
    end
  endtask

  task automatic test_ok_stall();
    rom = '{default: 16'h5678};
    obj_ok = 1'b1;
    start_draw(7'h05, 4'd3, 1'b0, 4'h2, 9'd40);
    @(negedge clk);
    checks++;
    if (obj_cs !== 1'b1 || buf_we !== 1'b0) begin failures++; $display("FAIL stall_first_ok got=cs%0b/we%0b exp=cs1/we0", obj_cs, buf_we); end
    obj_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obj_cs !== 1'b1 || obj_addr !== 13'h14C || buf_we !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d got=cs%0b/%0h/we%0b exp=cs1/14c/we0", i, obj_cs, obj_addr, buf_we);
      end
    end
    obj_ok = 1'b1;
    @(negedge clk);
    checks++;
    if (buf_we !== 1'b1 || buf_addr !== 9'd40 || buf_data !== 8'h25) begin
      failures++;
      $display("FAIL stall_pix0 got=%0b/%0d/%0h exp=1/40/25", buf_we, buf_addr, buf_data);
    end
    capture(100);
    checks++; if (cap_busy != 22 || cap_to) begin failures++; $display("FAIL stall_busy got=%0d exp=22", cap_busy); end
    checks++;
    if (cap_x.size() != 16) begin failures++; $display("FAIL stall_nwr got=%0d exp=16", cap_x.size()); end
    else begin
      checks++;
      if (cap_x[15] !== 9'd55 || cap_d[15] !== 8'h28) begin failures++; $display("FAIL stall_last got=%0d/%0h exp=55/28", cap_x[15], cap_d[15]); end
    end
  endtask

  task automatic test_busy_ignore();
    rom = '{default: 16'h1234};
    start_draw(7'h05, 4'd3, 1'b0, 4'hA, 9'd100);
    code = 7'h7F; vrow = 4'd9; hflip = 1'b1; pal = 4'h0; xpos = 9'd0; draw = 1'b1;
    capture(100);
    draw = 1'b0;
    checks++; if (cap_busy != 24 || cap_to) begin failures++; $display("FAIL ign_busy got=%0d exp=24", cap_busy); end
    checks++;
    if (cap_addr.size() != 4 || cap_addr[0] !== 13'h14C || cap_addr[3] !== 13'h14F) begin
      failures++;
      $display("FAIL ign_addr got=n%0d exp=n4 14c..14f", cap_addr.size());
    end
    checks++;
    if (cap_x.size() != 16 || cap_x[0] !== 9'd100 || cap_d[0] !== 8'hA1 || cap_d[15] !== 8'hA4) begin
      failures++;
      $display("FAIL ign_wr got=n%0d exp=n16 a1@100..a4@115", cap_x.size());
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_requeue got=%0b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    rom = '{default: 16'h1111};
    start_draw(7'h01, 4'd0, 1'b0, 4'h1, 9'd0);
    capture(100);
    // first IDLE cycle: a new request is accepted straight away
    start_draw(7'h02, 4'd1, 1'b0, 4'h1, 9'd200);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%0b exp=1", busy); end
    capture(100);
    checks++;
    if (cap_busy != 24 || cap_addr.size() != 4 || cap_addr[0] !== 13'h084) begin
      failures++;
      $display("FAIL b2b_row got=busy%0d/n%0d exp=busy24/n4/084", cap_busy, cap_addr.size());
    end
  endtask

  task automatic test_rst_mid();
    rom = '{default: 16'h1234};
    start_draw(7'h05, 4'd3, 1'b0, 4'hA, 9'd100);
    repeat (3) @(negedge clk);
    checks++; if (buf_we !== 1'b1 || buf_data !== 8'hA2) begin failures++; $display("FAIL rmid_pre got=%0b/%0h exp=1/a2", buf_we, buf_data); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, obj_cs, obj_addr, buf_addr, buf_data, buf_we} !== '0) begin
      failures++;
      $display("FAIL rmid_async got=%0h exp=0", {busy, obj_cs, obj_addr, buf_addr, buf_data, buf_we});
    end
    @(negedge clk);
    rst = 1'b0;
    start_draw(7'h02, 4'd1, 1'b0, 4'h3, 9'd20);
    capture(100);
    checks++;
    if (cap_busy != 24 || cap_addr.size() != 4 || cap_addr[0] !== 13'h084 || cap_addr[3] !== 13'h087) begin
      failures++;
      $display("FAIL rmid_addr got=busy%0d/n%0d exp=busy24/084..087", cap_busy, cap_addr.size());
    end
    checks++;
    if (cap_x.size() != 16 || cap_x[0] !== 9'd20 || cap_d[0] !== 8'h31 || cap_x[15] !== 9'd35 || cap_d[15] !== 8'h34) begin
      failures++;
      $display("FAIL rmid_wr got=n%0d exp=n16 31@20..34@35", cap_x.size());
    end
  endtask

  initial begin
    rst = 1'b1; draw = 1'b0; code = '0; vrow = '0; hflip = 1'b0;
    pal = '0; xpos = '0; obj_ok = 1'b0;
    rom = '{default: 16'h0000};
    test_reset();
    test_normal();
    test_hflip();
    test_wrap();
    test_ok_stall();
    test_busy_ignore();
    test_back_to_back();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jtframe_obj_draw.md
# jtframe_obj_draw

Sprite row drawer that fetches one 16-pixel, 4bpp object row from graphics ROM and writes it pixel by pixel into a line buffer. It sits downstream of the pause/avatar object-data mux: it drives the object ROM address and consumes the muxed 16-bit data and its ok flag. It emits line-buffer write strobes with palette-tagged pixels. One draw request covers one sprite row: 4 ROM words and 16 pixels.

## Interface
Parameters:
- CW, 7, sprite code width; ROM address width AW = CW+6 ({code, vrow[3:0], word[1:0]}); default AW = 13
- PW, 4, palette field width
- XW, 9, line-buffer x address width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- draw  in  1  start request; sampled only while idle
- code  in  CW  sprite code, latched on accepted draw
- vrow  in  4  row within sprite, latched
- hflip  in  1  horizontal flip, latched
- pal  in  PW  palette, latched
- xpos  in  XW  leftmost buffer x, latched
- busy  out  1  request in progress
- obj_cs  out  1  ROM read request
- obj_addr  out  CW+6  ROM word address
- obj_data  in  16  ROM data (from avatar mux)
- obj_ok  in  1  ROM data valid
- buf_addr  out  XW  line-buffer address
- buf_data  out  PW+4  {pal, pixel}
- buf_we  out  1  line-buffer write strobe

## Operation
- States: IDLE, FETCH, DRAW.
- IDLE: draw=1 latches all inputs; word index w=0; x=xpos; go to FETCH.
- FETCH: obj_cs=1; obj_addr={code, vrow, hflip ? 3-w : w}. obj_ok is ignored on the first FETCH cycle to avoid stale ok. From the second cycle on, obj_ok=1 latches obj_data and goes to DRAW with pixel index p=0.
- DRAW: obj_cs=0; one pixel per cycle.
  - Non-flipped: nibble p is obj_data[15-4p -: 4], so bits [15:12] come first.
  - Flipped: nibble p is bits [4p+3 : 4p], so bits [3:0] come first.
  - buf_addr=x; buf_data={pal, nibble}; buf_we=1 unless nibble==0 (transparent).
  - x increments every pixel, transparent or not.
  - After p=3: if w<3, then w++ and go to FETCH; else go to IDLE.
- x arithmetic is modulo 2^XW, so wrap-around from 511 to 0 is legal and writes continue.
- draw while busy is ignored; it is neither queued nor re-latched.
- Input changes after latch have no effect on the current request.
- Reset at any time: state IDLE immediately, all outputs 0, latched fields cleared.

## Timing
- Reset values: busy=0, obj_cs=0, obj_addr=0, buf_addr=0, buf_data=0, buf_we=0.
- draw high at edge N (idle) -> from N+1: busy=1, obj_cs=1, obj_addr valid.
- With obj_ok held high, each word costs 2 FETCH + 4 DRAW cycles, 24 cycles per row minimum.
  - busy deasserts at the edge after the last DRAW cycle.
  - A new draw is accepted at the first IDLE cycle, so back-to-back rows start every 25 cycles.
- obj_ok wait is unbounded; obj_cs and obj_addr stay stable until the data is accepted.
- obj_ok during DRAW or IDLE is ignored.
- buf_* outputs are registered and valid in the same cycle as the DRAW state. buf_we is exactly one cycle per opaque pixel.

## Structure
- Shared package jtframe_obj_pkg: state enum {IDLE, FETCH, DRAW}, constant OBJ_WORDS=4, constant OBJ_PXL_PER_WORD=4.
- One sub-module is natural: jtframe_obj_pxlsel. It is combinational, takes {data[15:0], p[1:0], hflip} and returns the 4-bit nibble. The FSM, counters and latches stay in the top module.

## Test plan
- code=7'h05, vrow=3, hflip=0, xpos=100, ROM returns 16'h1234 for every word with ok held high -> obj_addr sequence 0x14C,0x14D,0x14E,0x14F; writes at x=100..115 with pixels 1,2,3,4 repeated; pal tag correct; busy high 24 cycles.
- Same request with hflip=1 -> obj_addr order 0x14F..0x14C; pixels 4,3,2,1 repeated at x=100..115.
- Word 16'h0A00, xpos=510, hflip=0 -> buf_we only at x=511; x continues 0,1,... for the remaining pixels with no write on zero nibbles; wrap verified.
- ok stuck high from the previous word, then dropped for 5 cycles -> first FETCH cycle ignores ok; no data latched until ok returns; obj_addr stable throughout.
- draw pulsed while busy with different code -> ignored; original row completes unchanged.
- rst asserted mid-DRAW -> all outputs 0 asynchronously; after release, a new draw starts a clean row from word 0.
